// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared definitions for the hard-decision Viterbi decoder of
// the rate-1/2, K=3 code (generators 111 / 101).
//   NUM_STATES   : trellis state count
//   G0, G1       : generator taps over {u, u[n-1], u[n-2]}
//   expected_sym : code symbol emitted from a state for input bit u
//   next_state   : trellis successor for input bit u
//   sym_dist     : Hamming distance between two code symbols (branch metric)
package viterbi_pkg;

  localparam int unsigned NUM_STATES = 4;
  localparam logic [2:0]  G0         = 3'b111;
  localparam logic [2:0]  G1         = 3'b101;

  // State encoding {u[n-1], u[n-2]}
  typedef logic [1:0] state_t;
  typedef logic [1:0] sym_t;

  function automatic sym_t expected_sym(input state_t state, input logic u);
    logic [2:0] taps;
    taps = {u, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  function automatic state_t next_state(input state_t state, input logic u);
    return {u, state[1]};
  endfunction

  function automatic logic [1:0] sym_dist(input sym_t a, input sym_t b);
    sym_t x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs: 2-way add-compare-select for one trellis state.
//   pm0, pm1 : path metrics of predecessor 0 (lower index) and predecessor 1
//   bm0, bm1 : branch metrics of the two incoming transitions
//   pm_new   : surviving candidate metric (not yet normalised)
//   dec      : 1 when predecessor 1 survives; ties go to predecessor 0
module viterbi_acs #(
  parameter int unsigned PM_W = 8
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    cand0  = pm0 + PM_W'(bm0);
    cand1  = pm1 + PM_W'(bm1);
    dec    = (cand1 < cand0);
    pm_new = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for the encoder2 code
// (rate 1/2, K=3, generators 111/101) with register-exchange survivors.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   enable   : d_in carries a valid code symbol this cycle
//   d_in     : code symbol, [1] = g0 output, [0] = g1 output
//   d_out    : decoded bit, TB_DEPTH-1 enabled cycles after its symbol
//   valid_o  : d_out comes from a fully populated survivor path
//   err_cnt  : (only with VITERBI_ERRCNT_EN) saturating sum of the
//              per-symbol normalisation amount = best-path bit errors
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  d_in,
  output logic        d_out,
  output logic        valid_o
`ifdef VITERBI_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(TB_DEPTH);

  logic [PM_W-1:0]     pm        [NUM_STATES];
  logic [PM_W-1:0]     pm_acs    [NUM_STATES];
  logic                dec       [NUM_STATES];
  // The oldest survivor bit is only ever observed as it leaves through d_out,
  // so storage keeps TB_DEPTH-1 bits and the full-length path exists only
  // combinationally in surv_next.
  logic [TB_DEPTH-2:0] surv      [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_next [NUM_STATES];
  logic [PM_W-1:0]     pm_min;
  state_t              best;
  logic [CNT_W-1:0]    cnt;

  // State {a,b} is reached from {b,0} or {b,1} with input bit a.
  for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
    localparam state_t P0 = state_t'((s % 2) * 2);
    localparam state_t P1 = state_t'((s % 2) * 2 + 1);
    localparam logic   A  = ((s / 2) != 0);

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = sym_dist(d_in, expected_sym(P0, A));
    assign bm1 = sym_dist(d_in, expected_sym(P1, A));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (pm_acs[s]),
      .dec    (dec[s])
    );

    assign surv_next[s] = {(dec[s] ? surv[P1] : surv[P0]), A};
  end

  always_comb begin
    pm_min = pm_acs[0];
    best   = '0;
    for (int unsigned i = 1; i < NUM_STATES; i++) begin
      if (pm_acs[i] < pm_min) begin
        pm_min = pm_acs[i];
        best   = state_t'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_W'(4);
        surv[i] <= '0;
      end
      cnt     <= '0;
      d_out   <= 1'b0;
      valid_o <= 1'b0;
    end else if (enable) begin
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        pm[i]   <= pm_acs[i] - pm_min;
        surv[i] <= surv_next[i][TB_DEPTH-2:0];
      end
      if (cnt != CNT_W'(TB_DEPTH - 1)) cnt <= cnt + CNT_W'(1);
      valid_o <= (cnt == CNT_W'(TB_DEPTH - 1));
      d_out   <= surv_next[best][TB_DEPTH-1];
    end else begin
      valid_o <= 1'b0;
    end
  end

`ifdef VITERBI_ERRCNT_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_cnt} + 17'(pm_min);

  always_ff @(posedge clk) begin
    if (rst)         err_cnt <= '0;
    else if (enable) err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: randomized self-checking bench for viterbi_decoder.
// Source bits are encoded in the bench, optionally corrupted, and the decoded
// stream is compared with the source delayed by TB_DEPTH-1 enabled symbols.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 16;
  localparam int N_SRC    = 256 + TB_DEPTH - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] d_in;
  logic       d_out;
  logic       valid_o;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .d_in    (d_in),
    .d_out   (d_out),
    .valid_o (valid_o)
`ifdef VITERBI_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int   cnt;
  logic hist[$];
  logic exp_dout;
  logic exp_valid;
  logic u1, u2;
  logic src [N_SRC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (symbol count %0d, t=%0t)", tag, got, exp, cnt, $time);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] sym, input logic b, input logic chk);
    enable = en;
    d_in   = sym;
    @(posedge clk);
    #1;
    if (en) begin
      hist.push_back(b);
      cnt++;
      exp_valid = (cnt >= TB_DEPTH);
      exp_dout  = exp_valid ? hist[cnt - TB_DEPTH] : 1'b0;
    end else begin
      exp_valid = 1'b0;
    end
    check("valid_o", 32'(valid_o), 32'(exp_valid));
    if (chk) check("d_out", 32'(d_out), 32'(exp_dout));
  endtask

  // Encode one source bit, apply the error mask, and present it.
  task automatic send(input logic b, input logic [1:0] err, input logic chk);
    logic [1:0] sym;
    sym[1] = b ^ u1 ^ u2;
    sym[0] = b ^ u2;
    u2 = u1;
    u1 = b;
    step(1'b1, sym ^ err, b, chk);
  endtask

  task automatic gap();
    step(1'b0, 2'($urandom), 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b1;
    d_in   = 2'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    hist.delete();
    u1 = 1'b0;
    u2 = 1'b0;
    exp_dout  = 1'b0;
    exp_valid = 1'b0;
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
`ifdef VITERBI_ERRCNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
  endtask

  int gap_n;
  int burst_at;
  int nc;

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    d_in   = 2'b00;
    cnt    = 0;
    u1     = 1'b0;
    u2     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N_SRC; i++) src[i] = 1'($urandom);

    // All-zero data
    do_reset();
    for (int i = 0; i < 40; i++) send(1'b0, 2'b00, 1'b1);

    // Impulse: one 1 followed by zeros
    do_reset();
    send(1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 39; i++) send(1'b0, 2'b00, 1'b1);

    // Random stream, d_in[0] flipped on every 16th symbol
    do_reset();
    for (int i = 0; i < N_SRC; i++)
      send(src[i], (i < 256 && (i % 16) == 15) ? 2'b01 : 2'b00, 1'b1);
`ifdef VITERBI_ERRCNT_EN
    check("err_cnt", 32'(err_cnt), 32'd16);
`endif

    // Same stream with random enable gaps
    do_reset();
    for (int i = 0; i < N_SRC; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        gap_n = int'($urandom_range(1, 3));
        repeat (gap_n) gap();
      end
      send(src[i], (i < 256 && (i % 16) == 15) ? 2'b01 : 2'b00, 1'b1);
    end
    gap();
`ifdef VITERBI_ERRCNT_EN
    check("err_cnt_gaps", 32'(err_cnt), 32'd16);
`endif

    // Burst of 4 fully corrupted symbols; output compared again once recovered
    do_reset();
    burst_at = 50;
    for (int i = 0; i < 120 + TB_DEPTH - 1; i++) begin
      nc = cnt + 1;
      send(1'($urandom),
           (i >= burst_at && i < burst_at + 4) ? 2'b11 : 2'b00,
           (nc > burst_at && nc <= burst_at + 4 + 2 * TB_DEPTH) ? 1'b0 : 1'b1);
    end

    // Reset in the middle of a stream, then a fresh stream
    do_reset();
    for (int i = 0; i < 100; i++) send(1'($urandom), 2'b00, 1'b1);
    do_reset();
    for (int i = 0; i < 60; i++) send(1'($urandom), 2'b00, 1'b1);

    enable = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
